// File: rtl/sync_fifo_core_if.sv
// sync_fifo_core_if
//   Bundles the request/response signals of sync_fifo_core. The clock and
//   reset stay plain ports on the FIFO.
//
//   Handshake:
//   - wclk_en is a write request. It is accepted on a rising edge only when
//     full is low. full acts as the inverse of a write-ready.
//   - rd_en is a read request. It is accepted on a rising edge only when
//     empty is low. empty acts as the inverse of a read-valid.
//   - A request that is not accepted changes nothing except the sticky
//     error flags.
//
//   Modports
//     master : the user of the FIFO. It drives the requests, write data and
//              clr_err, and observes the data, status and error outputs.
//     slave  : the FIFO itself.
interface sync_fifo_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wclk_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wclk_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wclk_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_core.sv
// sync_fifo_core
//   Single-clock FIFO with flop-array storage. It keeps write and read
//   pointers, an occupancy counter, status flags decoded from that counter,
//   and sticky overflow/underflow flags.
//
//   FWFT = 0 : data_out is registered. It updates on the edge that accepts
//              a read, and otherwise holds its last value.
//   FWFT = 1 : data_out shows mem[rptr] combinationally and is valid
//              whenever empty is low. rd_en pops the word on data_out.
//
//   Ports
//     clk    : the single clock. All state changes on its rising edge.
//     rst_n  : asynchronous active-low reset. The storage array is not reset.
//     bus    : sync_fifo_core_if.slave. It carries wclk_en, data_in, rd_en,
//              data_out, full, empty, almost_full, almost_empty, count,
//              overflow, underflow and clr_err.
module sync_fifo_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 4,
  parameter bit FWFT   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_core_if.slave    bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic full, empty, wen, ren;

  // The flags decode the registered count. An operation therefore shows up
  // in the flags one cycle after the edge that performed it.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // At full, a simultaneous read still pops and the write is rejected.
  // At empty, a simultaneous write still lands and the read is rejected.
  assign wen = bus.wclk_en & ~full;
  assign ren = bus.rd_en   & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    // The pointers are ADDR_W bits wide, so they wrap from DEPTH-1 to 0
    // without any extra logic.
    if (wen) wptr_d = wptr_q + 1'b1;
    if (ren) rptr_d = rptr_q + 1'b1;

    unique case ({wen, ren})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ren) dout_d = mem_q[rptr_q];

    // clr_err is applied first, so a new error in the same cycle wins.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.wclk_en & full) ovf_d = 1'b1;
    if (bus.rd_en & empty)  udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // The storage array has no reset. After a reset, the old contents cannot
  // be reached because count returns to zero.
  always_ff @(posedge clk) begin
    if (wen) mem_q[wptr_q] <= bus.data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.data_out = mem_q[rptr_q];
    end else begin : g_std
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
